allpass_tdm_sched: RTL and testbench
====================================

ALLPASS_TDM_SCHED -- requirements
Module: allpass_tdm_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample/coefficient width (signed, Q1.(WIDTH-1)).
REQ-002 SHALL have parameter NCH, default 4, number of time-multiplexed channels (power of 2, >=2).
REQ-003 SHALL have parameter STAGES, default 2, cascaded first-order allpass stages per channel.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports cfg_we input 1, cfg_ch input log2(NCH), cfg_c input WIDTH: per-channel coefficient write.
REQ-007 SHALL have ports s_valid input 1, s_ready output 1, s_ch input log2(NCH), s_data input WIDTH: sample input handshake.
REQ-008 SHALL have ports m_valid output 1, m_ready input 1, m_ch output log2(NCH), m_data output WIDTH: result output handshake.
REQ-009 SHALL have port busy output 1, high whenever state is not IDLE.

Function
REQ-010 SHALL hold one coefficient register per channel and NCH*STAGES state registers s[ch][k], all WIDTH bits.
REQ-011 SHALL share one multiplier among all channels and stages; per stage: y = sat(c*x + s[ch][k]), then s[ch][k] <= sat(x - c*y).
REQ-012 SHALL form products at 2*WIDTH bits, arithmetic right shift by WIDTH-1 (truncation), add at WIDTH+1 bits, saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-013 SHALL use FSM states IDLE, CALC_Y, CALC_S, DONE.
REQ-014 SHALL drive s_ready=1 only in IDLE; s_valid&&s_ready latches s_ch, s_data, coefficient of s_ch, clears stage index k=0, enters CALC_Y.
REQ-015 CALC_Y SHALL register y for stage k and go to CALC_S.
REQ-016 CALC_S SHALL write s[ch][k]; if k<STAGES-1 set x<=y, k<=k+1, go CALC_Y; else load m_data<=y, m_ch<=ch, go DONE.
REQ-017 SHALL assert m_valid only in DONE, holding m_ch/m_data stable until m_valid&&m_ready, then return to IDLE.
REQ-018 Latency: m_valid SHALL rise exactly 2*STAGES clock edges after the accept edge; with m_ready=1 the next accept is possible 2*STAGES+2 edges after the previous.
REQ-019 A cfg write SHALL update the coefficient register on the same edge; a sample already in flight SHALL keep its latched coefficient, even when cfg_ch equals the active channel.
REQ-020 Simultaneous cfg write and sample accept on the same channel SHALL latch the old coefficient for that sample.
REQ-021 Channel states SHALL be fully independent; processing ch a SHALL never modify s[b][*] for b!=a.

Reset
REQ-022 rst low SHALL asynchronously force FSM to IDLE, k=0, all state registers and coefficients to 0, m_valid=0, m_data=0, m_ch=0, busy=0; s_ready=1 after release.
REQ-023 Reset mid-operation SHALL discard the in-flight sample without producing output; partially updated state registers are also cleared.

Structure
REQ-024 FSM state encoding and saturation width constants SHALL live in shared package allpass_pkg.
REQ-025 Multiply-shift-add-saturate SHALL be one combinational sub-module allpass_mac (inputs a, b, addend, sub flag; output saturated WIDTH result).
REQ-026 State storage SHALL be registers (no RAM inference required); expected RTL size 150-300 lines.

Verification
REQ-027 STAGES=2, c[0]=0, ch0 samples 1000,0,0,0 -> outputs 0,0,1000,0 (pure two-sample delay).
REQ-028 STAGES=1, c[1]=0x4000, ch1 samples 0x2000 then 0 -> outputs 0x1000 then 0x1800.
REQ-029 STAGES=1, c[2]=0x7FFF, ch2 samples 0x7FFF,0x7FFF -> outputs 0x7FFE then 0x7FFF (saturated).
REQ-030 Interleave ch0/ch3 with different coefficients; each channel's output equals its single-channel reference model; m_ready held low 5 cycles -> m_data/m_ch stable, s_ready=0 throughout.
REQ-031 cfg write to active channel during CALC_Y -> current output uses old coefficient, next sample uses new.
REQ-032 rst pulsed low in CALC_S -> m_valid stays 0, next sample with c=0 on same channel returns 0 (state cleared).

Source files
------------

// File: rtl/allpass_pkg.sv
// Shared definitions for the time-multiplexed allpass scheduler:
// FSM state encoding and the guard width used by the saturating accumulator.
package allpass_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_Y = 2'd1,
        CALC_S = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Guard bits above WIDTH for the add/subtract before saturation.
    localparam int SUM_GUARD = 1;

endpackage

// File: rtl/allpass_mac.sv
// Shared multiply / shift / add-or-subtract / saturate datapath.
// result = sat(addend +/- ((a*b) >>> (WIDTH-1))), Q1.(WIDTH-1) format.
module allpass_mac
    import allpass_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] addend,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] result
);

    localparam int SW = WIDTH + SUM_GUARD;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [SW-1:0]      term;
    logic signed [SW-1:0]      base;
    logic signed [SW-1:0]      sum;
    logic                      ovf;
    logic                      unused_lsbs;

    assign prod = a * b;
    // Upper bits of the product are exactly the truncating arithmetic shift by WIDTH-1.
    assign term = prod[2*WIDTH-1:WIDTH-1];
    assign unused_lsbs = ^prod[WIDTH-2:0];
    assign base = {{SUM_GUARD{addend[WIDTH-1]}}, addend};
    assign sum  = sub ? (base - term) : (base + term);

    always_comb begin
        ovf = (sum[SW-1:WIDTH-1] != '0) && (sum[SW-1:WIDTH-1] != '1);
        if (ovf) begin
            result = sum[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            result = sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/allpass_tdm_sched.sv
// Cascaded first-order allpass filter, time-multiplexed over NCH channels
// with one shared multiplier; each stage takes a y-step and an s-step.
//
// state  | meaning
// IDLE   | s_ready high, waiting for a sample
// CALC_Y | compute stage output y = sat(c*x + s[ch][k])
// CALC_S | update s[ch][k] = sat(x - c*y), advance stage or finish
// DONE   | m_valid high, holding result until m_ready
module allpass_tdm_sched
    import allpass_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int NCH    = 4,
    parameter  int STAGES = 2,
    localparam int CW     = $clog2(NCH),
    localparam int KW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [WIDTH-1:0] cfg_c,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [CW-1:0]    s_ch,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CW-1:0]    m_ch,
    output logic [WIDTH-1:0] m_data,
    output logic             busy
);

    localparam logic [KW-1:0] K_LAST = KW'(STAGES - 1);

    state_t                  state;
    logic [KW-1:0]           k;
    logic [CW-1:0]           ch_cur;
    logic signed [WIDTH-1:0] c_cur;
    logic signed [WIDTH-1:0] x_cur;
    logic signed [WIDTH-1:0] y_cur;
    logic signed [WIDTH-1:0] coef [NCH];
    logic signed [WIDTH-1:0] st   [NCH][STAGES];

    logic signed [WIDTH-1:0] mac_b;
    logic signed [WIDTH-1:0] mac_add;
    logic signed [WIDTH-1:0] mac_out;
    logic                    mac_sub;

    // A sample latches coef[] before this edge's write lands, so in-flight work keeps its coefficient.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) coef[i] <= '0;
        end else if (cfg_we) begin
            coef[cfg_ch] <= cfg_c;
        end
    end

    always_comb begin
        mac_b   = x_cur;
        mac_add = st[ch_cur][k];
        if (state == CALC_S) begin
            mac_b   = y_cur;
            mac_add = x_cur;
        end
    end

    assign mac_sub = (state == CALC_S);

    allpass_mac #(.WIDTH(WIDTH)) u_mac (
        .a      (c_cur),
        .b      (mac_b),
        .addend (mac_add),
        .sub    (mac_sub),
        .result (mac_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            k       <= '0;
            ch_cur  <= '0;
            c_cur   <= '0;
            x_cur   <= '0;
            y_cur   <= '0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            m_valid <= 1'b0;
            m_ch    <= '0;
            m_data  <= '0;
            for (int i = 0; i < NCH; i++) begin
                for (int j = 0; j < STAGES; j++) st[i][j] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        ch_cur  <= s_ch;
                        x_cur   <= s_data;
                        c_cur   <= coef[s_ch];
                        k       <= '0;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CALC_Y;
                    end
                end
                CALC_Y: begin
                    y_cur <= mac_out;
                    state <= CALC_S;
                end
                CALC_S: begin
                    st[ch_cur][k] <= mac_out;
                    if (k != K_LAST) begin
                        x_cur <= y_cur;
                        k     <= k + 1'b1;
                        state <= CALC_Y;
                    end else begin
                        m_data  <= y_cur;
                        m_ch    <= ch_cur;
                        m_valid <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_allpass_tdm_sched.sv
// Bench for allpass_tdm_sched: a STAGES=2 and a STAGES=1 instance checked
// every cycle against an arithmetic allpass model, plus literal vectors.
module tb_allpass_tdm_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we  [2];
    logic [1:0]  cfg_ch  [2];
    logic [15:0] cfg_c   [2];
    logic        s_valid [2];
    logic        s_ready [2];
    logic [1:0]  s_ch    [2];
    logic [15:0] s_data  [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic [1:0]  m_ch    [2];
    logic [15:0] m_data  [2];
    logic        busy    [2];

    int n_cmp = 0;
    int n_err = 0;

    int mcoef [2][4];
    int mst   [2][4][2];
    bit exp_busy [2];
    int edges    [2];
    int exp_ch   [2];
    int exp_data [2];

    always #5 clk = ~clk;

    allpass_tdm_sched #(.WIDTH(16), .NCH(4), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we[0]), .cfg_ch(cfg_ch[0]), .cfg_c(cfg_c[0]),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_ch(s_ch[0]), .s_data(s_data[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_ch(m_ch[0]), .m_data(m_data[0]),
        .busy(busy[0])
    );

    allpass_tdm_sched #(.WIDTH(16), .NCH(4), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we[1]), .cfg_ch(cfg_ch[1]), .cfg_c(cfg_c[1]),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_ch(s_ch[1]), .s_data(s_data[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_ch(m_ch[1]), .m_data(m_data[1]),
        .busy(busy[1])
    );

    function automatic int nst(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Textbook cascade: y = c*x + s ; s' = x - c*y ; next stage input is y.
    function automatic int run_model(input int d, input int ch, input int x, input int c);
        int xi;
        int y;
        xi = x;
        y  = 0;
        for (int k = 0; k < nst(d); k++) begin
            y = sat16(((c * xi) >>> 15) + mst[d][ch][k]);
            mst[d][ch][k] = sat16(xi - ((c * y) >>> 15));
            xi = y;
        end
        return y;
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, d, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        bit idle;
        bit exp_mv;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                exp_busy[d] = 1'b0;
                edges[d]    = 0;
                for (int c = 0; c < 4; c++) begin
                    mcoef[d][c] = 0;
                    for (int k = 0; k < 2; k++) mst[d][c][k] = 0;
                end
                chk("rst_m_valid", d, int'(m_valid[d]), 0);
                chk("rst_busy",    d, int'(busy[d]), 0);
                chk("rst_m_data",  d, int'(m_data[d]), 0);
                chk("rst_m_ch",    d, int'(m_ch[d]), 0);
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                idle = !exp_busy[d];
                if (exp_busy[d]) edges[d]++;
                exp_mv = exp_busy[d] && (edges[d] >= 2 * nst(d));
                chk("busy",    d, int'(busy[d]),    exp_busy[d] ? 1 : 0);
                chk("s_ready", d, int'(s_ready[d]), exp_busy[d] ? 0 : 1);
                chk("m_valid", d, int'(m_valid[d]), exp_mv ? 1 : 0);
                if (exp_mv) begin
                    chk("m_ch",   d, int'(m_ch[d]), exp_ch[d]);
                    chk("m_data", d, int'($signed(m_data[d])), exp_data[d]);
                    if (m_ready[d]) exp_busy[d] = 1'b0;
                end
                if (idle && s_valid[d]) begin
                    exp_ch[d]   = int'(s_ch[d]);
                    exp_data[d] = run_model(d, int'(s_ch[d]), int'($signed(s_data[d])),
                                            mcoef[d][s_ch[d]]);
                    exp_busy[d] = 1'b1;
                    edges[d]    = -1;
                end
                if (cfg_we[d]) mcoef[d][cfg_ch[d]] = int'($signed(cfg_c[d]));
            end
        end
    end

    task automatic cfg(input int d, input int ch, input int val);
        cfg_we[d] = 1'b1;
        cfg_ch[d] = 2'(ch);
        cfg_c[d]  = 16'(val);
        @(posedge clk); #1;
        cfg_we[d] = 1'b0;
    endtask

    // cfg_mode: 0 none, 1 write alongside s_valid, 2 write during CALC_Y.
    task automatic send(input int d, input int ch, input int data, input int cfg_mode,
                        input int cch, input int cval, input bit rnd_rdy, input int stall,
                        output int got);
        int n;
        int held;
        int first;
        bit done;
        s_ch[d]    = 2'(ch);
        s_data[d]  = 16'(data);
        s_valid[d] = 1'b1;
        if (cfg_mode == 1) begin
            cfg_we[d] = 1'b1; cfg_ch[d] = 2'(cch); cfg_c[d] = 16'(cval);
        end
        n = 0;
        while (!s_ready[d] && n < 100) begin
            @(posedge clk); #1;
            cfg_we[d] = 1'b0;
            n++;
        end
        @(posedge clk); #1;
        s_valid[d] = 1'b0;
        cfg_we[d]  = 1'b0;
        if (cfg_mode == 2) begin
            cfg_we[d] = 1'b1; cfg_ch[d] = 2'(cch); cfg_c[d] = 16'(cval);
        end
        if (stall > 0) m_ready[d] = 1'b0;
        got   = 0;
        done  = 1'b0;
        held  = 0;
        first = 0;
        n     = 0;
        while (!done && n < 200) begin
            if (rnd_rdy) m_ready[d] = ($urandom_range(0, 3) != 0);
            if (stall > 0 && held >= stall) m_ready[d] = 1'b1;
            @(negedge clk);
            if (m_valid[d] && m_ready[d]) begin
                got  = int'($signed(m_data[d]));
                done = 1'b1;
            end else if (m_valid[d] && stall > 0) begin
                if (held == 0) first = int'(m_data[d]);
                chk("stall_s_ready", d, int'(s_ready[d]), 0);
                chk("stall_hold",    d, int'(m_data[d]), first);
                held++;
            end
            @(posedge clk); #1;
            cfg_we[d] = 1'b0;
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout dut%0d ch%0d: got no output, required one", d, ch);
        end
        m_ready[d] = 1'b1;
    endtask

    initial begin : stim
        int got;
        int d;
        int ch;
        int mode;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cfg_we[i] = 1'b0; cfg_ch[i] = '0; cfg_c[i] = '0;
            s_valid[i] = 1'b0; s_ch[i] = '0; s_data[i] = '0;
            m_ready[i] = 1'b1;
        end
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_s_ready", 0, int'(s_ready[0]), 1);
        chk("reset_s_ready", 1, int'(s_ready[1]), 1);
        @(posedge clk); #1;

        // Zero coefficient on two stages is a pure two-sample delay.
        cfg(0, 0, 0);
        send(0, 0, 1000, 0, 0, 0, 0, 0, got); chk("delay_0", 0, got, 0);
        send(0, 0, 0,    0, 0, 0, 0, 0, got); chk("delay_1", 0, got, 0);
        send(0, 0, 0,    0, 0, 0, 0, 0, got); chk("delay_2", 0, got, 1000);
        send(0, 0, 0,    0, 0, 0, 0, 0, got); chk("delay_3", 0, got, 0);

        cfg(1, 1, 16'h4000);
        send(1, 1, 16'h2000, 0, 0, 0, 0, 0, got); chk("half_0", 1, got, 16'h1000);
        send(1, 1, 0,        0, 0, 0, 0, 0, got); chk("half_1", 1, got, 16'h1800);

        cfg(1, 2, 16'h7FFF);
        send(1, 2, 16'h7FFF, 0, 0, 0, 0, 0, got); chk("sat_0", 1, got, 16'h7FFE);
        send(1, 2, 16'h7FFF, 0, 0, 0, 0, 0, got); chk("sat_1", 1, got, 16'h7FFF);

        // Interleaved channels with distinct coefficients, one long output stall.
        cfg(0, 0, 16'h2000);
        cfg(0, 3, 16'hD000);
        for (int i = 0; i < 8; i++) begin
            send(0, (i % 2) ? 3 : 0, $urandom_range(0, 65535), 0, 0, 0, 0,
                 (i == 3) ? 5 : 0, got);
        end

        // Coefficient rewrite while the same channel is mid-computation.
        send(0, 3, 16'h3000, 2, 3, 16'h5000, 0, 0, got);
        send(0, 3, 16'h1000, 0, 0, 0, 0, 0, got);
        // Write and accept on the same edge and channel.
        send(0, 3, 16'h0800, 1, 3, 16'h9000, 0, 0, got);
        send(0, 3, 16'h0800, 0, 0, 0, 0, 0, got);

        // Reset while the sample is in CALC_S.
        cfg(0, 1, 16'h3000);
        send(0, 1, 16'h4000, 0, 0, 0, 0, 0, got);
        send(0, 1, 16'h1000, 0, 0, 0, 0, 0, got);
        s_ch[0] = 2'd1; s_data[0] = 16'h2000; s_valid[0] = 1'b1;
        @(posedge clk); #1;
        s_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(0, 1, 16'h1234, 0, 0, 0, 0, 0, got); chk("after_rst", 0, got, 0);

        for (int c = 0; c < 4; c++) begin
            cfg(0, c, $urandom_range(0, 65535));
            cfg(1, c, $urandom_range(0, 65535));
        end
        for (int i = 0; i < 160; i++) begin
            d    = $urandom_range(0, 1);
            ch   = $urandom_range(0, 3);
            mode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            send(d, ch, $urandom_range(0, 65535), mode,
                 ($urandom_range(0, 1) != 0) ? ch : $urandom_range(0, 3),
                 $urandom_range(0, 65535), ($urandom_range(0, 1) != 0), 0, got);
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
